// File: rtl/ast_serializer_pkg.sv
// Shared types and helpers for the wide-to-narrow Avalon-ST serializer.
package ast_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of narrow slices needed to carry the valid bytes of a word.
  function automatic int unsigned slice_count(input int unsigned in_bytes,
                                              input int unsigned out_bytes,
                                              input int unsigned empty);
    return (in_bytes - empty + out_bytes - 1) / out_bytes;
  endfunction

endpackage

// File: rtl/avalon_st.sv
// Avalon-ST bundle used to hook the serializer up on either side.
interface avalon_st #(
  parameter int DATA_W    = 16,
  parameter int CHANNEL_W = 10,
  parameter int EMPTY_W   = 1
) ();
  logic [DATA_W-1:0]    data;
  logic [CHANNEL_W-1:0] channel;
  logic [EMPTY_W-1:0]   empty;
  logic                 sop;
  logic                 eop;
  logic                 valid;
  logic                 ready;

  modport source (output data, channel, empty, sop, eop, valid, input ready);
  modport sink   (input data, channel, empty, sop, eop, valid, output ready);
endinterface

// File: rtl/ast_serializer.sv
// Splits each wide Avalon-ST word into DATA_IN_W/DATA_OUT_W narrow slices,
// MSB slice first, trimming trailing slices of an eop word by its empty count.
module ast_serializer
  import ast_serializer_pkg::*;
#(
  parameter int DATA_IN_W  = 64,
  parameter int DATA_OUT_W = 16,
  parameter int CHANNEL_W  = 10,
  localparam int EMPTY_IN_W  = $clog2(DATA_IN_W / 8),
  localparam int EMPTY_OUT_W = $clog2(DATA_OUT_W / 8)
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic [DATA_IN_W-1:0]   snk_data_i,
  input  logic [CHANNEL_W-1:0]   snk_channel_i,
  input  logic [EMPTY_IN_W-1:0]  snk_empty_i,
  input  logic                   snk_sop_i,
  input  logic                   snk_eop_i,
  input  logic                   snk_valid_i,
  output logic                   snk_ready_o,
  output logic [DATA_OUT_W-1:0]  src_data_o,
  output logic [CHANNEL_W-1:0]   src_channel_o,
  output logic [EMPTY_OUT_W-1:0] src_empty_o,
  output logic                   src_sop_o,
  output logic                   src_eop_o,
  output logic                   src_valid_o,
  input  logic                   src_ready_i
);

  localparam int unsigned R         = DATA_IN_W / DATA_OUT_W;
  localparam int unsigned IN_BYTES  = DATA_IN_W / 8;
  localparam int unsigned OUT_BYTES = DATA_OUT_W / 8;
  localparam int          IDX_W     = (R > 1) ? $clog2(R) : 1;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       idx, last_idx, last_idx_n;
  logic [DATA_IN_W-1:0]   word;
  logic [CHANNEL_W-1:0]   chan;
  logic                   word_sop, word_eop;
  logic [EMPTY_OUT_W-1:0] last_empty, last_empty_n;
  logic                   armed;
  logic                   last, snk_xfer, src_xfer;
  int unsigned            cnt;

  assign last     = (idx == last_idx);
  assign snk_xfer = snk_valid_i && snk_ready_o;
  assign src_xfer = src_valid_o && src_ready_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (snk_xfer) state_next = SEND;
      SEND: if (src_xfer && last) state_next = snk_xfer ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready may rise in SEND only when the final slice leaves, so the next
  // word reloads the buffer on the same edge without a bubble.
  always_comb begin
    src_valid_o   = (state == SEND);
    snk_ready_o   = armed && ((state == IDLE) || (src_ready_i && last));
    src_data_o    = src_valid_o ? word[DATA_IN_W-1 -: DATA_OUT_W] : '0;
    src_channel_o = src_valid_o ? chan : '0;
    src_sop_o     = src_valid_o && word_sop && (idx == '0);
    src_eop_o     = src_valid_o && word_eop && last;
    src_empty_o   = (src_valid_o && last) ? last_empty : '0;
  end

  always_comb begin
    cnt          = slice_count(IN_BYTES, OUT_BYTES, 32'(snk_empty_i));
    last_idx_n   = snk_eop_i ? IDX_W'(cnt - 1) : IDX_W'(R - 1);
    last_empty_n = snk_eop_i ? EMPTY_OUT_W'(cnt * OUT_BYTES - (IN_BYTES - 32'(snk_empty_i)))
                             : '0;
  end

  // Buffer shifts left per slice so the outgoing slice is always the MSBs.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      armed      <= 1'b0;
      idx        <= '0;
      last_idx   <= '0;
      word       <= '0;
      chan       <= '0;
      word_sop   <= 1'b0;
      word_eop   <= 1'b0;
      last_empty <= '0;
    end else begin
      armed <= 1'b1;
      if (snk_xfer) begin
        idx        <= '0;
        last_idx   <= last_idx_n;
        word       <= snk_data_i;
        chan       <= snk_channel_i;
        word_sop   <= snk_sop_i;
        word_eop   <= snk_eop_i;
        last_empty <= last_empty_n;
      end else if (src_xfer) begin
        idx  <= idx + IDX_W'(1);
        word <= word << DATA_OUT_W;
      end
    end
  end

endmodule
